// File: rtl/dec_pkg.sv
// Shared constants and types for the decoder dense layers.
// All datapath words are signed Q8.8.
package dec_pkg;

  localparam int unsigned FRAC = 8;

  localparam logic [15:0] ONE  = 16'h0100;
  localparam logic [15:0] ZERO = 16'h0000;

  localparam int unsigned ACT_NONE = 0;
  localparam int unsigned ACT_RELU = 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

endpackage

// File: rtl/dec_4_mac.sv
// Single multiply-accumulate step: sum = (sel_bias ? bias : acc) + trunc(z*w >>> FRAC).
module dec_4_mac
  import dec_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = dec_pkg::FRAC
) (
  input  logic [BITSIZE-1:0] z_elem,
  input  logic [BITSIZE-1:0] w_elem,
  input  logic [BITSIZE-1:0] bias,
  input  logic [BITSIZE-1:0] acc,
  input  logic               sel_bias,
  output logic [BITSIZE-1:0] sum
);

  logic [BITSIZE-1:0] p;
  logic [BITSIZE-1:0] addend;

  fixed_point_multiply #(
    .BITSIZE(BITSIZE),
    .FRAC   (FRAC)
  ) u_mul (
    .a     (z_elem),
    .b     (w_elem),
    .result(p)
  );

  assign addend = sel_bias ? bias : acc;

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_add (
    .a     (addend),
    .b     (p),
    .result(sum)
  );

endmodule

// File: rtl/fixed_point_add.sv
// Two's-complement add that wraps modulo 2^BITSIZE.
module fixed_point_add #(
  parameter int unsigned BITSIZE = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] result
);

  assign result = a + b;

endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// low BITSIZE bits kept (wraps, no saturation). Requires FRAC >= 1.
module fixed_point_multiply #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = 8
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] result
);

  logic signed [2*BITSIZE-1:0] a_ext;
  logic signed [2*BITSIZE-1:0] b_ext;
  logic signed [2*BITSIZE-1:0] prod;
  logic                        unused_prod_bits;

  assign a_ext = {{BITSIZE{a[BITSIZE-1]}}, a};
  assign b_ext = {{BITSIZE{b[BITSIZE-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Taking bits [FRAC +: BITSIZE] equals (prod >>> FRAC) truncated to BITSIZE.
  assign result = prod[FRAC +: BITSIZE];

  assign unused_prod_bits = ^{prod[2*BITSIZE-1:FRAC+BITSIZE], prod[FRAC-1:0]};

endmodule

// File: rtl/dec_4.sv
// Time-multiplexed dense layer y = act(W*z + b) with one shared MAC and
// valid/ready handshakes on both sides.
module dec_4
  import dec_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = dec_pkg::FRAC,
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_OUT   = 6,
  parameter int unsigned ACT     = ACT_NONE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BITSIZE*N_IN-1:0]       z,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic [BITSIZE*N_OUT-1:0]      y,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  state_e state_q, state_d;

  logic [BITSIZE*N_IN-1:0]       z_q;
  logic [BITSIZE*N_IN*N_OUT-1:0] w_q;
  logic [BITSIZE*N_OUT-1:0]      b_q;
  logic [BITSIZE-1:0]            acc_q;
  logic [BITSIZE-1:0]            y_q [N_OUT];
  logic [IW-1:0]                 i_q, i_d;
  logic [OW-1:0]                 o_q, o_d;

  logic [BITSIZE-1:0] z_arr [N_IN];
  logic [BITSIZE-1:0] w_arr [N_OUT][N_IN];
  logic [BITSIZE-1:0] b_arr [N_OUT];

  logic               accept;
  logic               in_mac;
  logic               elem_last;
  logic               last_pair;
  logic [BITSIZE-1:0] sum;
  logic [BITSIZE-1:0] act_val;

  // Operand views and output packing.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_z
    assign z_arr[gi] = z_q[BITSIZE*gi +: BITSIZE];
  end

  for (genvar go = 0; go < N_OUT; go++) begin : g_row
    assign b_arr[go] = b_q[BITSIZE*go +: BITSIZE];
    assign y[BITSIZE*go +: BITSIZE] = y_q[go];
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_col
      assign w_arr[go][gi] = w_q[BITSIZE*(N_IN*go+gi) +: BITSIZE];
    end
  end

  assign accept    = in_valid && in_ready;
  assign in_mac    = (state_q == MAC);
  assign elem_last = (i_q == I_LAST);
  assign last_pair = in_mac && elem_last && (o_q == O_LAST);

  dec_4_mac #(
    .BITSIZE(BITSIZE),
    .FRAC   (FRAC)
  ) u_mac (
    .z_elem  (z_arr[i_q]),
    .w_elem  (w_arr[o_q][i_q]),
    .bias    (b_arr[o_q]),
    .acc     (acc_q),
    .sel_bias(i_q == '0),
    .sum     (sum)
  );

  always_comb begin
    act_val = sum;
    if (ACT == ACT_RELU && sum[BITSIZE-1]) begin
      act_val = '0;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (last_pair) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Counters walk i fastest, then o; they park at zero once the pass ends.
  always_comb begin
    i_d = i_q;
    o_d = o_q;
    if (accept || last_pair) begin
      i_d = '0;
      o_d = '0;
    end else if (in_mac) begin
      if (elem_last) begin
        i_d = '0;
        o_d = o_q + OW'(1);
      end else begin
        i_d = i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q   <= '0;
      w_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      o_q   <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      i_q <= i_d;
      o_q <= o_d;
      if (accept) begin
        z_q <= z;
        w_q <= w;
        b_q <= b;
      end
      if (in_mac) begin
        acc_q <= sum;
        if (elem_last) begin
          y_q[o_q] <= act_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_4.sv
// Directed bench for dec_4: identity and ReLU instances share stimulus, a
// scoreboard queue holds the expected results of every accepted operand set.
module tb_dec_4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [31:0]  z;
  logic [191:0] w;
  logic [95:0]  b;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [95:0]  y0, y1;

  typedef struct packed {
    logic [95:0] y_id;
    logic [95:0] y_relu;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dec_4 #(.ACT(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .z        (z),
    .w        (w),
    .b        (b),
    .y        (y0),
    .out_valid(out_valid0),
    .out_ready(out_ready)
  );

  dec_4 #(.ACT(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .z        (z),
    .w        (w),
    .b        (b),
    .y        (y1),
    .out_valid(out_valid1),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: Q8.8 products truncated after >>> 8, 16-bit wrapping sums.
  function automatic exp_t model(input logic [31:0] zz, input logic [191:0] ww,
                                 input logic [95:0] bb);
    exp_t               e;
    logic [15:0]        acc;
    logic signed [31:0] prod;
    for (int o = 0; o < 6; o++) begin
      acc = bb[16*o +: 16];
      for (int i = 0; i < 2; i++) begin
        prod = $signed(zz[16*i +: 16]) * $signed(ww[16*(2*o+i) +: 16]);
        acc  = acc + prod[23:8];
      end
      e.y_id[16*o +: 16]   = acc;
      e.y_relu[16*o +: 16] = acc[15] ? 16'h0000 : acc;
    end
    return e;
  endfunction

  // Returns at the falling edge right after the acceptance edge (T0).
  task automatic send(input logic [31:0] zz, input logic [191:0] ww, input logic [95:0] bb);
    int n = 0;
    @(negedge clk);
    z = zz; w = ww; b = bb; in_valid = 1'b1;
    while (!in_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("send_timeout", in_ready0, 96'd1);
    sb.push_back(model(zz, ww, bb));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    z = $urandom();
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
  endtask

  // Waits for a result, optionally stalls it while offering new operands,
  // then compares against the scoreboard and completes the handshake.
  task automatic receive(input int hold);
    int   n = 0;
    exp_t e;
    while (!out_valid0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("result_timeout", out_valid0, 96'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 96'd0, 96'd1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b1;
        z = 32'h7fff_7fff;
        w = {6{32'h0100_0100}};
        b = {3{32'h1111_1111}};
      end
      if (k == 3) in_valid = 1'b0;
      check("bp_y_id", y0, e.y_id);
      check("bp_out_valid", out_valid0, 96'd1);
      check("bp_in_ready", in_ready0, 96'd0);
    end
    in_valid = 1'b0;
    check("y_id", y0, e.y_id);
    check("y_relu", y1, e.y_relu);
    check("valid_relu_inst", out_valid1, 96'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid0, 96'd0);
    check("post_hs_in_ready", in_ready0, 96'd1);
  endtask

  logic [191:0] w_ones, w_neg_row0, w_trunc;
  logic [31:0]  z_12;
  exp_t         e;
  int           acc_cnt, res_cnt;
  int           acc_cyc[2];
  int           hs_cyc[2];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    z = '0; w = '0; b = '0;
    z_12       = {16'h0200, 16'h0100};
    w_ones     = {12{16'h0100}};
    w_neg_row0 = {{10{16'h0100}}, 16'hff00, 16'hff00};
    w_trunc    = {6{16'h0000, 16'h0001}};
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", y0, 96'd0);
    check("reset_in_ready", in_ready0, 96'd1);
    check("reset_out_valid", out_valid0, 96'd0);
    @(negedge clk);
    reset = 1'b0;

    // Identity sum with latency probes.
    send(z_12, w_ones, 96'd0);
    check("mac_in_ready", in_ready0, 96'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("y0_before_T2", y0[15:0], 96'd0);
      if (k == 2) check("y0_at_T2", y0[15:0], 96'h0300);
      if (k == 11) check("out_valid_T11", out_valid0, 96'd0);
      if (k == 12) check("out_valid_T12", out_valid0, 96'd1);
    end
    receive(0);

    // Negative row: identity keeps 0xFD00, ReLU clamps to zero.
    send(z_12, w_neg_row0, 96'd0);
    receive(0);

    // Truncation toward -inf of -0.5 * 1/256 plus bias.
    send({16'h1234, 16'hff80}, w_trunc, {6{16'h0010}});
    receive(0);

    // Backpressure with ignored operands offered in DONE.
    send({16'hfe80, 16'h0180}, {$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()});
    receive(5);
    repeat (3) begin
      @(negedge clk);
      check("no_capture_out_valid", out_valid0, 96'd0);
      check("no_capture_in_ready", in_ready0, 96'd1);
    end

    // Reset in the middle of MAC.
    send(z_12, w_neg_row0, {6{16'h0040}});
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midmac_y", y0, 96'd0);
    check("midmac_y_relu", y1, 96'd0);
    check("midmac_out_valid", out_valid0, 96'd0);
    check("midmac_in_ready", in_ready0, 96'd1);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    send(z_12, w_ones, {6{16'h0001}});
    receive(0);

    // Random operand sets.
    repeat (3) begin
      send($urandom(), {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom()}, {$urandom(), $urandom(), $urandom()});
      receive(0);
    end

    // Back-to-back with out_ready held high.
    acc_cnt = 0; res_cnt = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; hs_cyc[0] = 0; hs_cyc[1] = 0;
    @(negedge clk);
    z = z_12; w = w_neg_row0; b = {6{16'h0100}};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && res_cnt < 2; c++) begin
      if (in_valid && in_ready0) begin
        sb.push_back(model(z, w, b));
        acc_cyc[acc_cnt] = c;
        acc_cnt++;
      end
      if (out_valid0 && out_ready) begin
        e = sb.pop_front();
        check("b2b_y_id", y0, e.y_id);
        check("b2b_y_relu", y1, e.y_relu);
        hs_cyc[res_cnt] = c;
        res_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc_cnt == 1) begin
        z = {16'hff00, 16'h0300}; w = w_ones; b = {6{16'hfff0}};
      end
      if (acc_cnt == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("b2b_results", res_cnt, 96'd2);
    check("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], 96'd14);
    check("b2b_accept_after_hs", acc_cyc[1] - hs_cyc[0], 96'd1);
    check("sb_empty", sb.size(), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
